multicycle_main_fsm: RTL

//  Main control FSM for the multicycle RV32I core; sits directly upstream of ALUControl.
//  - Decodes op[6:0] and sequences one instruction over 3-5 cycles.
//  - Drives aluOp (consumed by ALUControl) plus all datapath mux, write-enable and PC controls.
//  - Supports lw, sw, R-type, I-type ALU, beq and jal; immSrc is combinational from op.

---
 rtl/multicycle_main_fsm.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Main control FSM for a multicycle RV32I core (lw, sw, R-type, I-type ALU,
//   beq, jal). It sequences each instruction over 3-5 cycles. aluOp feeds
//   ALUControl. The other outputs drive the datapath muxes, the write enables
//   and the PC.
//   Optional build macro MCFSM_MEM_STALL_EN adds a memReady input. With it,
//   FETCH and MEMREAD wait for memory, and MEMWRITE holds its strobe until
//   memory acknowledges.
module multicycle_main_fsm #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
`ifdef MCFSM_MEM_STALL_EN
   input  logic               memReady,
`endif
   input  logic [6:0]         op,
   input  logic               zero,
   output logic               pcWrite,
   output logic               adrSrc,
   output logic               memWrite,
   output logic               irWrite,
   output logic               regWrite,
   output logic [1:0]         resultSrc,
   output logic [1:0]         aluSrcA,
   output logic [1:0]         aluSrcB,
   output logic [1:0]         aluOp,
   output logic [1:0]         immSrc,
   output logic               illegalOp,
   output logic [COUNT_W-1:0] retireCnt
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t state, state_next;
   logic   mem_ready;
   logic   pc_update;
   logic   branch;
   logic   retire;

`ifdef MCFSM_MEM_STALL_EN
   assign mem_ready = memReady;
`else
   assign mem_ready = 1'b1;
`endif

   // The edge that leaves a final state completes the instruction.
   assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                   ((state == S_MEMWRITE) && mem_ready);

   // State register and retired-instruction counter. Reset takes priority over any stall.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state     <= S_FETCH;
         retireCnt <= '0;
      end else begin
         state <= state_next;
         if (retire) retireCnt <= retireCnt + COUNT_W'(1);
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = S_FETCH;
      case (state)
         S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECR;
               OP_I:         state_next = S_EXECI;
               OP_JAL:       state_next = S_JAL;
               OP_BEQ:       state_next = S_BEQ;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_JAL:      state_next = S_ALUWB;
         S_BEQ:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   // Moore control outputs from the state, plus the op-dependent immSrc and illegalOp.
   always_comb begin
      adrSrc    = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      resultSrc = 2'b00;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      illegalOp = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (op)
         OP_SW:   immSrc = 2'b01;
         OP_BEQ:  immSrc = 2'b10;
         OP_JAL:  immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
      case (state)
         S_FETCH: begin
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            irWrite   = mem_ready;
            pc_update = mem_ready;
         end
         S_DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegalOp = 1'b0;
               default:                                 illegalOp = 1'b1;
            endcase
         end
         S_MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
         end
         S_MEMREAD:  adrSrc = 1'b1;
         S_MEMWB: begin
            resultSrc = 2'b01;
            regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc   = 1'b1;
            memWrite = 1'b1;
         end
         S_EXECR: begin
            aluSrcA = 2'b10;
            aluOp   = 2'b10;
         end
         S_EXECI: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            aluOp   = 2'b10;
         end
         S_ALUWB:    regWrite = 1'b1;
         S_JAL: begin
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            aluSrcA = 2'b10;
            aluOp   = 2'b01;
            branch  = 1'b1;
         end
         default: begin
            adrSrc = 1'b0;
         end
      endcase
      // While reset is high, every control output is held low.
      if (reset) begin
         adrSrc    = 1'b0;
         memWrite  = 1'b0;
         irWrite   = 1'b0;
         regWrite  = 1'b0;
         resultSrc = 2'b00;
         aluSrcA   = 2'b00;
         aluSrcB   = 2'b00;
         aluOp     = 2'b00;
         immSrc    = 2'b00;
         illegalOp = 1'b0;
         pc_update = 1'b0;
         branch    = 1'b0;
      end
   end

   assign pcWrite = pc_update | (branch & zero);

endmodule
